// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Division support is compiled in only when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit signed/unsigned divider for the MDU.
// Handles divide-by-zero and the signed overflow case explicitly.
module mdu_div
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dz
);

  logic [31:0] ma, mb, uq, ur;
  logic        neg_q, neg_r;

  always_comb begin
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ma    = (sgn & a[31]) ? -a : a;
    mb    = (sgn & b[31]) ? -b : b;
    dz    = (b == 32'd0);
    uq    = '0;
    ur    = '0;
    q     = '0;
    r     = '0;
    if (dz) begin
      q = '0;
      r = '0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      // magnitude divide, then restore signs: truncation toward zero
      uq = ma / mb;
      ur = ma % mb;
      q  = neg_q ? -uq : uq;
      r  = neg_r ? -ur : ur;
    end
  end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit with architectural HI/LO.
// Define MDU_DIV_EN to build div/divu; otherwise they act as no-ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW =
    ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_t, lo_t;
  logic          upd;
  logic          sx;
  logic [63:0]   prod;

  // low 64 bits of the extended product equal the signed product
  always_comb begin
    sx   = (op == MDU_MULT);
    prod = {{32{sx & A[31]}}, A} * {{32{sx & B[31]}}, B};
  end

`ifdef MDU_DIV_EN
  logic [31:0] quo, rem;
  logic        dz;

  mdu_div u_div (
    .a   (A),
    .b   (B),
    .sgn (op == MDU_DIV),
    .q   (quo),
    .r   (rem),
    .dz  (dz)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      hi_t  <= '0;
      lo_t  <= '0;
      upd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                hi_t  <= prod[63:32];
                lo_t  <= prod[31:0];
                upd   <= 1'b1;
                cnt   <= CW'(MULT_LAT);
                state <= RUN;
                busy  <= 1'b1;
              end
`ifdef MDU_DIV_EN
              MDU_DIV, MDU_DIVU: begin
                hi_t  <= rem;
                lo_t  <= quo;
                upd   <= ~dz;
                cnt   <= CW'(DIV_LAT);
                state <= RUN;
                busy  <= 1'b1;
              end
`endif
              MDU_MTHI: hi <= A;
              MDU_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            if (upd) begin
              hi <= hi_t;
              lo <= lo_t;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
